// File: rtl/half_adder_pipe.sv
// half_adder_pipe
// Lane-parallel registered half adder with a valid/ready interface.
// Each beat is evaluated when it is accepted and parked in a main output
// register backed by one skid entry, so in_ready comes straight from a flop
// and never depends combinationally on out_ready.

module half_adder_pipe #(
  parameter int WIDTH = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [WIDTH-1:0]               a,
  input  logic [WIDTH-1:0]               b,
  input  logic                           in_valid,
  output logic                           in_ready,
  output logic [WIDTH-1:0]               sum,
  output logic [WIDTH-1:0]               cout,
  output logic                           cout_any,
  output logic [$clog2(WIDTH+1)-1:0]     cout_count,
  output logic                           out_valid,
  input  logic                           out_ready
);

  localparam int CW = $clog2(WIDTH + 1);
  // Stored beat layout: {sum, cout, cout_any, cout_count}
  localparam int BW = 2 * WIDTH + 1 + CW;

  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_ONE   = 2'd1;
  localparam logic [1:0] OCC_TWO   = 2'd2;

  // Number of carries produced by one beat, for the adder-tree summary.
  function automatic logic [CW-1:0] popcount(input logic [WIDTH-1:0] v);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < WIDTH; i++) begin
      c = c + CW'(v[i]);
    end
    return c;
  endfunction

  logic [1:0]       occ_r;
  logic [1:0]       occ_nxt_s;
  logic             out_valid_r;
  logic             in_ready_r;
  logic [BW-1:0]    main_r;
  logic [BW-1:0]    main_nxt_s;
  logic [BW-1:0]    skid_r;
  logic [BW-1:0]    skid_nxt_s;
  logic [WIDTH-1:0] new_sum_s;
  logic [WIDTH-1:0] new_cout_s;
  logic [BW-1:0]    new_beat_s;
  logic             accept_s;
  logic             consume_s;

  // Evaluate the incoming operands so the result is frozen at acceptance.
  always_comb begin
    new_sum_s  = a ^ b;
    new_cout_s = a & b;
    new_beat_s = {new_sum_s, new_cout_s, |new_cout_s, popcount(new_cout_s)};
    accept_s   = in_valid & in_ready_r;
    consume_s  = out_valid_r & out_ready;
  end

  // Occupancy and storage next-state: main register plus one skid entry.
  always_comb begin
    occ_nxt_s  = occ_r;
    main_nxt_s = main_r;
    skid_nxt_s = skid_r;
    case (occ_r)
      OCC_EMPTY: begin
        if (accept_s) begin
          main_nxt_s = new_beat_s;
          occ_nxt_s  = OCC_ONE;
        end else begin
          occ_nxt_s  = OCC_EMPTY;
        end
      end
      OCC_ONE: begin
        if (accept_s && consume_s) begin
          // Pass-through: new beat replaces the one leaving.
          main_nxt_s = new_beat_s;
          occ_nxt_s  = OCC_ONE;
        end else if (accept_s) begin
          skid_nxt_s = new_beat_s;
          occ_nxt_s  = OCC_TWO;
        end else if (consume_s) begin
          // Main keeps its last value while empty.
          occ_nxt_s  = OCC_EMPTY;
        end else begin
          occ_nxt_s  = OCC_ONE;
        end
      end
      OCC_TWO: begin
        // in_ready is low here, so no accept can coincide.
        if (consume_s) begin
          main_nxt_s = skid_r;
          occ_nxt_s  = OCC_ONE;
        end else begin
          occ_nxt_s  = OCC_TWO;
        end
      end
      default: begin
        occ_nxt_s = OCC_EMPTY;
      end
    endcase
  end

  // State registers; handshake flags are derived from next occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_r       <= OCC_EMPTY;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
      main_r      <= '0;
      skid_r      <= '0;
    end else begin
      occ_r       <= occ_nxt_s;
      out_valid_r <= (occ_nxt_s != OCC_EMPTY);
      in_ready_r  <= (occ_nxt_s != OCC_TWO);
      main_r      <= main_nxt_s;
      skid_r      <= skid_nxt_s;
    end
  end

  assign in_ready   = in_ready_r;
  assign out_valid  = out_valid_r;
  assign sum        = main_r[BW-1 -: WIDTH];
  assign cout       = main_r[BW-WIDTH-1 -: WIDTH];
  assign cout_any   = main_r[CW];
  assign cout_count = main_r[CW-1:0];

endmodule

// File: tb/tb_half_adder_pipe.sv
// Directed and random checks for half_adder_pipe (WIDTH = 8).
// Inputs are driven 1 ns after each rising edge; outputs are sampled there too.

module tb_half_adder_pipe;

  localparam int WIDTH = 8;
  localparam int CW    = 4;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] cout;
  logic             cout_any;
  logic [CW-1:0]    cout_count;
  logic             out_valid;
  logic             out_ready;

  int n_checks;
  int n_fail;

  // Observed word: {out_valid, in_ready, sum, cout, cout_any, cout_count}
  logic [22:0] obs;
  assign obs = {out_valid, in_ready, sum, cout, cout_any, cout_count};

  half_adder_pipe #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .a          (a),
    .b          (b),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .sum        (sum),
    .cout       (cout),
    .cout_any   (cout_any),
    .cout_count (cout_count),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    a = 8'hFF; b = 8'hFF; in_valid = 1'b1; out_ready = 1'b1;
    #2 rst_n = 1'b0;
    step();
    step();
    n_checks++;
    if (obs !== {1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 4'd0}) begin
      n_fail++;
      $display("FAIL reset_during: got %h expected %h", obs, {1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 4'd0});
    end
    in_valid = 1'b0;
    rst_n = 1'b1;
    step();
    n_checks++;
    if (obs !== {1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 4'd0}) begin
      n_fail++;
      $display("FAIL reset_after: got %h expected %h", obs, {1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 4'd0});
    end
  endtask

  task automatic test_truth_table();
    logic [7:0]  va [4];
    logic [7:0]  vb [4];
    logic [22:0] ve [4];
    va[0] = 8'h00; vb[0] = 8'h00; ve[0] = {1'b1, 1'b1, 8'h00, 8'h00, 1'b0, 4'd0};
    va[1] = 8'h01; vb[1] = 8'h00; ve[1] = {1'b1, 1'b1, 8'h01, 8'h00, 1'b0, 4'd0};
    va[2] = 8'h00; vb[2] = 8'h01; ve[2] = {1'b1, 1'b1, 8'h01, 8'h00, 1'b0, 4'd0};
    va[3] = 8'h01; vb[3] = 8'h01; ve[3] = {1'b1, 1'b1, 8'h00, 8'h01, 1'b1, 4'd1};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a = va[i]; b = vb[i]; in_valid = 1'b1;
      step();
      n_checks++;
      if (obs !== ve[i]) begin
        n_fail++;
        $display("FAIL truth_table[%0d]: got %h expected %h", i, obs, ve[i]);
      end
    end
    in_valid = 1'b0;
    step();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL truth_drain: out_valid got %b expected 0", out_valid);
    end
  endtask

  task automatic test_lane_independence();
    out_ready = 1'b1;
    a = 8'hF0; b = 8'hCC; in_valid = 1'b1;
    step();
    n_checks++;
    if (obs !== {1'b1, 1'b1, 8'h3C, 8'hC0, 1'b1, 4'd2}) begin
      n_fail++;
      $display("FAIL lanes_f0_cc: got %h expected %h", obs, {1'b1, 1'b1, 8'h3C, 8'hC0, 1'b1, 4'd2});
    end
    a = 8'hFF; b = 8'hFF;
    step();
    n_checks++;
    if (obs !== {1'b1, 1'b1, 8'h00, 8'hFF, 1'b1, 4'd8}) begin
      n_fail++;
      $display("FAIL lanes_ff_ff: got %h expected %h", obs, {1'b1, 1'b1, 8'h00, 8'hFF, 1'b1, 4'd8});
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    a = 8'h12; b = 8'h34; in_valid = 1'b1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_ready_initial: got %b expected 1", in_ready);
    end
    step();
    n_checks++;
    if (obs !== {1'b1, 1'b1, 8'h26, 8'h10, 1'b1, 4'd1}) begin
      n_fail++;
      $display("FAIL bp_first: got %h expected %h", obs, {1'b1, 1'b1, 8'h26, 8'h10, 1'b1, 4'd1});
    end
    a = 8'hAA; b = 8'h55;
    step();
    n_checks++;
    if (obs !== {1'b1, 1'b0, 8'h26, 8'h10, 1'b1, 4'd1}) begin
      n_fail++;
      $display("FAIL bp_full: got %h expected %h", obs, {1'b1, 1'b0, 8'h26, 8'h10, 1'b1, 4'd1});
    end
    a = 8'h0F; b = 8'h0F;
    for (int i = 0; i < 2; i++) begin
      step();
      n_checks++;
      if (obs !== {1'b1, 1'b0, 8'h26, 8'h10, 1'b1, 4'd1}) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: got %h expected %h", i, obs, {1'b1, 1'b0, 8'h26, 8'h10, 1'b1, 4'd1});
      end
    end
    out_ready = 1'b1;
    step();
    n_checks++;
    if (obs !== {1'b1, 1'b1, 8'hFF, 8'h00, 1'b0, 4'd0}) begin
      n_fail++;
      $display("FAIL bp_second: got %h expected %h", obs, {1'b1, 1'b1, 8'hFF, 8'h00, 1'b0, 4'd0});
    end
    step();
    n_checks++;
    if (obs !== {1'b1, 1'b1, 8'h00, 8'h0F, 1'b1, 4'd4}) begin
      n_fail++;
      $display("FAIL bp_third: got %h expected %h", obs, {1'b1, 1'b1, 8'h00, 8'h0F, 1'b1, 4'd4});
    end
    in_valid = 1'b0;
    step();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_drain: out_valid got %b expected 0", out_valid);
    end
  endtask

  task automatic test_streaming();
    logic [20:0] q [$];
    logic [20:0] exp_beat;
    logic [7:0]  c;
    int sent;
    int recv;
    int cyc;
    logic acc;
    sent = 0; recv = 0; cyc = 0;
    in_valid = 1'b0;
    while ((sent < 256 || recv < sent) && cyc < 4000) begin
      if (!in_valid && sent < 256 && $urandom_range(0, 3) != 0) begin
        a = 8'($urandom);
        b = 8'($urandom);
        in_valid = 1'b1;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      if (out_valid && out_ready) begin
        n_checks++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL stream_extra: unexpected beat %h", obs[20:0]);
        end else begin
          exp_beat = q.pop_front();
          if (obs[20:0] !== exp_beat) begin
            n_fail++;
            $display("FAIL stream_beat[%0d]: got %h expected %h", recv, obs[20:0], exp_beat);
          end
        end
        recv++;
      end
      acc = in_valid && in_ready;
      if (acc) begin
        c = a & b;
        q.push_back({a ^ b, c, (c != 8'h00), 4'($countones(c))});
        sent++;
      end
      step();
      if (acc) in_valid = 1'b0;
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    n_checks++;
    if (cyc >= 4000 || recv != 256 || q.size() != 0) begin
      n_fail++;
      $display("FAIL stream_totals: recv %0d left %0d cycles %0d expected recv 256 left 0", recv, q.size(), cyc);
    end
    step();
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    a = 8'h11; b = 8'h11; in_valid = 1'b1;
    step();
    a = 8'h22; b = 8'h33;
    step();
    in_valid = 1'b0;
    n_checks++;
    if ({out_valid, in_ready} !== 2'b10) begin
      n_fail++;
      $display("FAIL arst_prefull: got %b expected 10", {out_valid, in_ready});
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (obs !== {1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 4'd0}) begin
      n_fail++;
      $display("FAIL arst_immediate: got %h expected %h", obs, {1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 4'd0});
    end
    #2 rst_n = 1'b1;
    step();
    out_ready = 1'b1;
    a = 8'h3C; b = 8'h0F; in_valid = 1'b1;
    step();
    n_checks++;
    if (obs !== {1'b1, 1'b1, 8'h33, 8'h0C, 1'b1, 4'd2}) begin
      n_fail++;
      $display("FAIL arst_after: got %h expected %h", obs, {1'b1, 1'b1, 8'h33, 8'h0C, 1'b1, 4'd2});
    end
    in_valid = 1'b0;
    step();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL arst_drain: out_valid got %b expected 0", out_valid);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    rst_n = 1'b1;
    a = 8'h00; b = 8'h00; in_valid = 1'b0; out_ready = 1'b0;
    test_reset();
    test_truth_table();
    test_lane_independence();
    test_backpressure();
    test_streaming();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
